// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer: buffered write-side initiator for the 32x32 register file.
// Writeback requests are queued in a small FIFO and drained one per cycle onto
// the register file write port. Combinational forwarding lets readers see
// values that are still queued or in flight.
// Optional build macro: REGFILE_WB_COALESCE_EN (merge a push into the newest
// entry when the destination register matches).
module regfile_wb_writer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_addr,
  input  logic [DW-1:0]            req_data,
  input  logic                     hold,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_rw,
  output logic [DW-1:0]            rf_w,
  input  logic [AW-1:0]            ra,
  input  logic [AW-1:0]            rb,
  output logic                     fwd_a_hit,
  output logic [DW-1:0]            fwd_a,
  output logic                     fwd_b_hit,
  output logic [DW-1:0]            fwd_b,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic          pop;
  logic          push_fire;
  logic          coalesce;
  logic          alloc;
  logic [PW-1:0] newest_idx;
  logic [PW-1:0] scan_idx;

  // Handshake and FIFO control decisions, all from current state and inputs
  always_comb begin
    req_ready  = (count_q < CW'(DEPTH));
    pop        = (count_q != '0) && !hold;
    push_fire  = req_valid && req_ready && (req_addr != '0);
    newest_idx = PW'(tail_q - PW'(1));
`ifdef REGFILE_WB_COALESCE_EN
    // The newest entry cannot absorb a push if it is the head leaving this edge
    coalesce   = push_fire && (count_q != '0) && (addr_q[newest_idx] == req_addr) &&
                 !((count_q == CW'(1)) && pop);
`else
    coalesce   = 1'b0;
`endif
    alloc      = push_fire && !coalesce;
  end

  // FIFO storage; contents are don't-care outside the valid window
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (alloc) begin
        addr_q[tail_q] <= req_addr;
        data_q[tail_q] <= req_data;
      end else if (coalesce) begin
        data_q[newest_idx] <= req_data;
      end
    end
  end

  // Pointers, occupancy and the registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rf_we   <= 1'b0;
      rf_rw   <= '0;
      rf_w    <= '0;
    end else begin
      if (alloc) begin
        tail_q <= PW'(tail_q + PW'(1));
      end
      if (pop) begin
        head_q <= PW'(head_q + PW'(1));
        rf_we  <= 1'b1;
        rf_rw  <= addr_q[head_q];
        rf_w   <= data_q[head_q];
      end else begin
        rf_we  <= 1'b0;
      end
      case ({alloc, pop})
        2'b10:   count_q <= CW'(count_q + CW'(1));
        2'b01:   count_q <= CW'(count_q - CW'(1));
        default: count_q <= count_q;
      endcase
    end
  end

  assign pending = count_q;

  // Read forwarding: in-flight write has lowest priority, then FIFO oldest to
  // newest so the youngest matching entry wins; register 0 never forwards
  always_comb begin
    fwd_a_hit = 1'b0;
    fwd_a     = '0;
    fwd_b_hit = 1'b0;
    fwd_b     = '0;
    scan_idx  = head_q;
    if (rf_we && (rf_rw == ra)) begin
      fwd_a_hit = 1'b1;
      fwd_a     = rf_w;
    end
    if (rf_we && (rf_rw == rb)) begin
      fwd_b_hit = 1'b1;
      fwd_b     = rf_w;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx = PW'(head_q + PW'(k));
      if (CW'(k) < count_q) begin
        if (addr_q[scan_idx] == ra) begin
          fwd_a_hit = 1'b1;
          fwd_a     = data_q[scan_idx];
        end
        if (addr_q[scan_idx] == rb) begin
          fwd_b_hit = 1'b1;
          fwd_b     = data_q[scan_idx];
        end
      end
    end
    if (ra == '0) begin
      fwd_a_hit = 1'b0;
      fwd_a     = '0;
    end
    if (rb == '0) begin
      fwd_b_hit = 1'b0;
      fwd_b     = '0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Testbench for regfile_wb_writer: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
// Honours REGFILE_WB_COALESCE_EN when the same macro is defined for the build.
module tb_regfile_wb_writer;

  localparam int DEPTH = 4;
`ifdef REGFILE_WB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        hold;
  logic        rf_we;
  logic [4:0]  rf_rw;
  logic [31:0] rf_w;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        fwd_a_hit;
  logic [31:0] fwd_a;
  logic        fwd_b_hit;
  logic [31:0] fwd_b;
  logic [2:0]  pending;

  int errors = 0;
  int checks = 0;

  regfile_wb_writer #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .hold(hold),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_w(rf_w),
    .ra(ra), .rb(rb),
    .fwd_a_hit(fwd_a_hit), .fwd_a(fwd_a),
    .fwd_b_hit(fwd_b_hit), .fwd_b(fwd_b),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the DUT write port (read-during-write returns old)
  logic [31:0] regs [32];
  always @(posedge clk) if (rf_we) regs[rf_rw] <= rf_w;

  // Behavioural model: queue of pending writes plus the in-flight write
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_rw;
  logic [31:0] m_w;

  task automatic model_step();
    bit   rdy, pop, push, coal;
    ent_t e;
    rdy  = (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && !hold;
    push = req_valid && rdy && (req_addr != 0);
    coal = COAL && push && (mq.size() > 0) && (mq[mq.size()-1].a == req_addr) &&
           !((mq.size() == 1) && pop);
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_rw = '0; m_w = '0;
    end else begin
      if (pop) begin
        e = mq.pop_front();
        m_we = 1'b1; m_rw = e.a; m_w = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (coal) begin
        e = mq[mq.size()-1];
        e.d = req_data;
        mq[mq.size()-1] = e;
      end else if (push) begin
        e.a = req_addr; e.d = req_data;
        mq.push_back(e);
      end
    end
  endtask

  function automatic logic [32:0] model_fwd(input logic [4:0] r);
    if (r == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == r) return {1'b1, mq[i].d};
    if (m_we && m_rw == r) return {1'b1, m_w};
    return '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit r, input bit v, input logic [4:0] a, input logic [31:0] d,
                       input bit h, input logic [4:0] xa, input logic [4:0] xb);
    rst = r; req_valid = v; req_addr = a; req_data = d; hold = h; ra = xa; rb = xb;
  endtask

  task automatic check_model(input string tag);
    logic [32:0] fa, fb;
    fa = model_fwd(ra);
    fb = model_fwd(rb);
    chk({tag, " rf_we"}, 32'(rf_we), 32'(m_we));
    chk({tag, " rf_rw"}, 32'(rf_rw), 32'(m_rw));
    chk({tag, " rf_w"}, rf_w, m_w);
    chk({tag, " pending"}, 32'(pending), 32'(mq.size()));
    chk({tag, " req_ready"}, 32'(req_ready), 32'(mq.size() < DEPTH));
    chk({tag, " fwd_a_hit"}, 32'(fwd_a_hit), 32'(fa[32]));
    chk({tag, " fwd_a"}, fwd_a, fa[31:0]);
    chk({tag, " fwd_b_hit"}, 32'(fwd_b_hit), 32'(fb[32]));
    chk({tag, " fwd_b"}, fwd_b, fb[31:0]);
  endtask

  // Directed vectors: inputs applied at an edge, expected outputs after it
  typedef struct {
    bit r, v; logic [4:0] a; logic [31:0] d; bit h; logic [4:0] xa, xb;
    bit we; logic [4:0] rw; logic [31:0] w; int pend; bit rdy;
    bit ah; logic [31:0] fa; bit bh; logic [31:0] fb;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit v, input logic [4:0] a, input logic [31:0] d,
                     input bit h, input logic [4:0] xa, input logic [4:0] xb,
                     input bit we, input logic [4:0] rw, input logic [31:0] w,
                     input int pend, input bit rdy, input bit ah, input logic [31:0] fa,
                     input bit bh, input logic [31:0] fb);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.d = d; t.h = h; t.xa = xa; t.xb = xb;
    t.we = we; t.rw = rw; t.w = w; t.pend = pend; t.rdy = rdy;
    t.ah = ah; t.fa = fa; t.bh = bh; t.fb = fb;
    tbl.push_back(t);
  endtask

  initial begin
    int p2;
    int nwrites;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    drive(1, 0, 0, 0, 0, 0, 0);
    p2 = COAL ? 1 : 2;

    // reset
    add(1,0,0,0,0,0,0,                 0,0,0,0,1, 0,0,0,0);
    // single write of r3, forwarded while queued and in flight
    add(0,1,3,32'hFFFFFFFF,0,3,0,      0,0,0,1,1, 1,32'hFFFFFFFF,0,0);
    add(0,0,0,0,0,3,0,                 1,3,32'hFFFFFFFF,0,1, 1,32'hFFFFFFFF,0,0);
    add(0,0,0,0,0,3,0,                 0,3,32'hFFFFFFFF,0,1, 0,0,0,0);
    // fill under hold, then drain in order
    add(0,1,1,32'h100,1,0,0,           0,3,32'hFFFFFFFF,1,1, 0,0,0,0);
    add(0,1,2,32'h101,1,0,0,           0,3,32'hFFFFFFFF,2,1, 0,0,0,0);
    add(0,1,3,32'h102,1,0,0,           0,3,32'hFFFFFFFF,3,1, 0,0,0,0);
    add(0,1,4,32'h103,1,2,4,           0,3,32'hFFFFFFFF,4,0, 1,32'h101,1,32'h103);
    add(0,0,0,0,0,0,0,                 1,1,32'h100,3,1, 0,0,0,0);
    add(0,0,0,0,0,0,0,                 1,2,32'h101,2,1, 0,0,0,0);
    add(0,0,0,0,0,0,0,                 1,3,32'h102,1,1, 0,0,0,0);
    add(0,0,0,0,0,0,0,                 1,4,32'h103,0,1, 0,0,0,0);
    add(0,0,0,0,0,0,0,                 0,4,32'h103,0,1, 0,0,0,0);
    // newest-wins forwarding, discarded r0 push
    add(0,1,5,32'hA,1,0,0,             0,4,32'h103,1,1, 0,0,0,0);
    add(0,1,5,32'hB,1,5,0,             0,4,32'h103,p2,1, 1,32'hB,0,0);
    add(0,1,0,32'h55,1,5,0,            0,4,32'h103,p2,1, 1,32'hB,0,0);
`ifdef REGFILE_WB_COALESCE_EN
    add(0,0,0,0,0,5,0,                 1,5,32'hB,0,1, 1,32'hB,0,0);
    add(0,0,0,0,0,5,0,                 0,5,32'hB,0,1, 0,0,0,0);
`else
    add(0,0,0,0,0,5,0,                 1,5,32'hA,1,1, 1,32'hB,0,0);
    add(0,0,0,0,0,5,0,                 1,5,32'hB,0,1, 1,32'hB,0,0);
`endif
    add(0,0,0,0,0,0,0,                 0,5,32'hB,0,1, 0,0,0,0);
    // in-flight forward lasts exactly one cycle
    add(0,1,7,32'h77,0,7,0,            0,5,32'hB,1,1, 1,32'h77,0,0);
    add(0,0,0,0,0,7,0,                 1,7,32'h77,0,1, 1,32'h77,0,0);
    add(0,0,0,0,0,7,0,                 0,7,32'h77,0,1, 0,0,0,0);
    // reset with three queued entries
    add(0,1,10,32'hA0,1,0,0,           0,7,32'h77,1,1, 0,0,0,0);
    add(0,1,11,32'hA1,1,0,0,           0,7,32'h77,2,1, 0,0,0,0);
    add(0,1,12,32'hA2,1,0,0,           0,7,32'h77,3,1, 0,0,0,0);
    add(1,0,0,0,0,0,0,                 0,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,0,0,0,                 0,0,0,0,1, 0,0,0,0);
    add(0,0,0,0,0,0,0,                 0,0,0,0,1, 0,0,0,0);
    // same-address pushes: coalesced or two writes depending on build
    add(0,1,9,32'h1,1,0,0,             0,0,0,1,1, 0,0,0,0);
    add(0,1,9,32'h2,1,0,0,             0,0,0,p2,1, 0,0,0,0);
`ifdef REGFILE_WB_COALESCE_EN
    add(0,0,0,0,0,0,0,                 1,9,32'h2,0,1, 0,0,0,0);
    add(0,0,0,0,0,0,0,                 0,9,32'h2,0,1, 0,0,0,0);
`else
    add(0,0,0,0,0,0,0,                 1,9,32'h1,1,1, 0,0,0,0);
    add(0,0,0,0,0,0,0,                 1,9,32'h2,0,1, 0,0,0,0);
`endif
    add(0,0,0,0,0,0,0,                 0,9,32'h2,0,1, 0,0,0,0);

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].xa, tbl[i].xb);
      step();
      chk({tag, " rf_we"}, 32'(rf_we), 32'(tbl[i].we));
      chk({tag, " rf_rw"}, 32'(rf_rw), 32'(tbl[i].rw));
      chk({tag, " rf_w"}, rf_w, tbl[i].w);
      chk({tag, " pending"}, 32'(pending), 32'(tbl[i].pend));
      chk({tag, " req_ready"}, 32'(req_ready), 32'(tbl[i].rdy));
      chk({tag, " fwd_a_hit"}, 32'(fwd_a_hit), 32'(tbl[i].ah));
      chk({tag, " fwd_a"}, fwd_a, tbl[i].fa);
      chk({tag, " fwd_b_hit"}, 32'(fwd_b_hit), 32'(tbl[i].bh));
      chk({tag, " fwd_b"}, fwd_b, tbl[i].fb);
      if (i == 3) chk("regfile r3", regs[3], 32'hFFFFFFFF);
      if (i == 27) begin
        chk("no write r10 after reset", regs[10], 32'h0);
        chk("no write r12 after reset", regs[12], 32'h0);
      end
      if (i == 32) chk("regfile r9", regs[9], 32'h2);
    end

    // Full FIFO with a pop: no same-cycle refill
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 5'(20 + k), 32'h200 + 32'(k), 1, 0, 0);
      step();
    end
    chk("full ready", 32'(req_ready), 32'h0);
    drive(0, 1, 24, 32'hDEAD, 0, 0, 0); step();
    chk("full pop pending", 32'(pending), 32'd3);
    chk("full pop rw", 32'(rf_rw), 32'd20);
    check_model("fullpop");
    nwrites = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      if (rf_we) nwrites++;
      check_model("drain");
    end
    chk("full drain writes", 32'(nwrites), 32'd4);
    chk("blocked push never written", regs[24], 32'h0);

    // Same address as a head that leaves this edge: a new entry is allocated
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 6, 32'h1, 1, 0, 0); step();
    drive(0, 1, 6, 32'h2, 0, 6, 0); step();
    chk("headpop pending", 32'(pending), 32'd1);
    chk("headpop rf_w", rf_w, 32'h1);
    chk("headpop fwd", fwd_a, 32'h2);
    drive(0, 0, 0, 0, 0, 6, 0); step();
    chk("headpop second write", rf_w, 32'h2);
    chk("headpop second we", 32'(rf_we), 32'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 4,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
      check_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
